// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_checker
// Description : Exhaustive stimulus sweep and self-check of an N-input,
//               single-output combinational gate (AND/OR/XOR/NAND).
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_checker #(
    parameter int N      = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [N-1:0]     stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N-1:0]     first_err_vec,
    output logic             first_err_valid
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [1:0] c_AND  = 2'b00;
    localparam logic [1:0] c_OR   = 2'b01;
    localparam logic [1:0] c_XOR  = 2'b10;

    // Counter reaches SETTLE on the edge that leaves WAIT, so it must hold it.
    localparam int               c_SW          = $clog2(SETTLE + 1);
    localparam logic [c_SW-1:0]  c_SETTLE_LAST = c_SW'(SETTLE - 1);
    localparam logic [N-1:0]     c_LAST_VEC    = {N{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [1:0]       r_mode;
    logic [N-1:0]     r_stim;
    logic [c_SW-1:0]  r_settle;
    logic             r_busy;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_count;
    logic [N-1:0]     r_first_err_vec;
    logic             r_first_err_valid;
    logic             w_expected;
    logic             w_mismatch;

    always_comb begin
        w_expected = 1'b0;
        case (r_mode)
            c_AND:   w_expected = &r_stim;
            c_OR:    w_expected = |r_stim;
            c_XOR:   w_expected = ^r_stim;
            default: w_expected = ~&r_stim;
        endcase
    end

    // Case-inequality so an unknown DUT output is reported as a mismatch.
    assign w_mismatch = (dut_y !== w_expected);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_WAIT;
            c_WAIT:  if (r_settle == c_SETTLE_LAST) w_next_state = c_CHECK;
            c_CHECK: w_next_state = (r_stim == c_LAST_VEC) ? c_DONE : c_WAIT;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= c_IDLE;
            r_mode            <= 2'b00;
            r_stim            <= '0;
            r_settle          <= '0;
            r_busy            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mode            <= mode;
                        r_stim            <= '0;
                        r_settle          <= '0;
                        r_err_count       <= '0;
                        r_first_err_vec   <= '0;
                        r_first_err_valid <= 1'b0;
                        r_pass            <= 1'b0;
                        r_busy            <= 1'b1;
                    end
                end
                c_WAIT: begin
                    r_settle <= r_settle + 1'b1;
                end
                c_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != {ERR_W{1'b1}})
                            r_err_count <= r_err_count + 1'b1;
                        if (!r_first_err_valid) begin
                            r_first_err_vec   <= r_stim;
                            r_first_err_valid <= 1'b1;
                        end
                    end
                    if (r_stim != c_LAST_VEC) begin
                        r_stim   <= r_stim + 1'b1;
                        r_settle <= '0;
                    end
                end
                default: begin
                    // DONE: err_count already includes the last vector's result.
                    r_pass <= (r_err_count == '0);
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign stim            = r_stim;
    assign busy            = r_busy;
    assign done            = (r_state == c_DONE);
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_vec   = r_first_err_vec;
    assign first_err_valid = r_first_err_valid;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_checker
// Description : Directed, table-driven bench for gate_sweep_checker using a
//               2-input and a 3-input instance with behavioural gate DUTs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_checker;

    localparam int c_K_AND = 0, c_K_OR = 1, c_K_XOR = 2, c_K_NAND = 3, c_K_ST0 = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [1:0] mode0, mode1;
    int         kind0, kind1;
    logic       dut_y0, dut_y1;

    logic [1:0] stim0, fv0;
    logic [2:0] stim1, fv1;
    logic [7:0] err0;
    logic [1:0] err1;
    logic       busy0, done0, pass0, fvl0;
    logic       busy1, done1, pass1, fvl1;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    always #5 clk = ~clk;

    gate_sweep_checker #(.N(2), .SETTLE(1), .ERR_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .stim(stim0),
        .dut_y(dut_y0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_vec(fv0), .first_err_valid(fvl0)
    );

    gate_sweep_checker #(.N(3), .SETTLE(2), .ERR_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .stim(stim1),
        .dut_y(dut_y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_vec(fv1), .first_err_valid(fvl1)
    );

    function automatic logic gate_f(input int kind, input logic [2:0] v, input int n);
        logic a, o, x;
        a = (n == 2) ? &v[1:0] : &v;
        o = (n == 2) ? |v[1:0] : |v;
        x = (n == 2) ? ^v[1:0] : ^v;
        case (kind)
            c_K_AND:  return a;
            c_K_OR:   return o;
            c_K_XOR:  return x;
            c_K_NAND: return ~a;
            default:  return 1'b0;
        endcase
    endfunction

    assign dut_y0 = gate_f(kind0, {1'b0, stim0}, 2);
    assign dut_y1 = gate_f(kind1, stim1, 3);

    // Observation mux for the instance under test.
    logic [2:0] ob_stim, ob_fv;
    logic [7:0] ob_err;
    logic       ob_busy, ob_done, ob_pass, ob_fvl;
    always_comb begin
        ob_stim = (sel == 1) ? stim1 : {1'b0, stim0};
        ob_fv   = (sel == 1) ? fv1 : {1'b0, fv0};
        ob_err  = (sel == 1) ? {6'd0, err1} : err0;
        ob_busy = (sel == 1) ? busy1 : busy0;
        ob_done = (sel == 1) ? done1 : done0;
        ob_pass = (sel == 1) ? pass1 : pass0;
        ob_fvl  = (sel == 1) ? fvl1 : fvl0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 1) start1 = v; else start0 = v;
    endtask

    task automatic set_mode(input logic [1:0] m);
        if (sel == 1) mode1 = m; else mode0 = m;
    endtask

    // One sweep: stim ordering is checked every cycle; a stray start with a
    // flipped mode is injected mid-sweep and must be ignored.
    task automatic run_sweep(input logic [1:0] m, input int kind,
                             output int done_at, output bit stim_ok);
        int per, nv, d;
        bit ok;
        per = (sel == 1) ? 3 : 2;
        nv  = (sel == 1) ? 8 : 4;
        if (sel == 1) kind1 = kind; else kind0 = kind;
        set_mode(m);
        set_start(1'b1);
        @(posedge clk);
        #1 set_start(1'b0);
        d  = -1;
        ok = 1'b1;
        for (int k = 1; k <= 60 && d < 0; k++) begin
            @(negedge clk);
            if (k == 3) begin set_start(1'b1); set_mode(~m); end
            if (k == 4) set_start(1'b0);
            if (k <= nv * per && int'(ob_stim) != (k - 1) / per) ok = 1'b0;
            if (ob_done) begin
                d = k;
                if (int'(ob_stim) != nv - 1) ok = 1'b0;
            end
        end
        @(negedge clk);
        done_at = d;
        stim_ok = ok;
    endtask

    typedef struct {
        int         s;
        logic [1:0] mode;
        int         kind;
        int         exp_err;
        int         exp_fv;
        int         exp_fvl;
        int         exp_pass;
        int         exp_lat;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int  done_at, d1, d2, nd, k;
        bit  stim_ok;

        tbl[0] = '{0, 2'b00, c_K_AND,  0, 0, 0, 1, 9};
        tbl[1] = '{0, 2'b00, c_K_OR,   2, 1, 1, 0, 9};
        tbl[2] = '{1, 2'b10, c_K_XOR,  0, 0, 0, 1, 25};
        tbl[3] = '{1, 2'b11, c_K_ST0,  3, 0, 1, 0, 25};
        tbl[4] = '{0, 2'b10, c_K_XOR,  0, 0, 0, 1, 9};
        tbl[5] = '{0, 2'b11, c_K_AND,  4, 0, 1, 0, 9};
        tbl[6] = '{1, 2'b01, c_K_AND,  3, 1, 1, 0, 25};
        tbl[7] = '{0, 2'b01, c_K_XOR,  1, 3, 1, 0, 9};
        tbl[8] = '{1, 2'b00, c_K_AND,  0, 0, 0, 1, 25};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        mode0 = 2'b00; mode1 = 2'b00; kind0 = c_K_AND; kind1 = c_K_AND;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #1;
            chk("reset_stim",  int'(ob_stim), 0);
            chk("reset_busy",  int'(ob_busy), 0);
            chk("reset_done",  int'(ob_done), 0);
            chk("reset_pass",  int'(ob_pass), 0);
            chk("reset_err",   int'(ob_err),  0);
            chk("reset_fvl",   int'(ob_fvl),  0);
            chk("reset_fv",    int'(ob_fv),   0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            sel = tbl[i].s;
            #1;
            run_sweep(tbl[i].mode, tbl[i].kind, done_at, stim_ok);
            chk($sformatf("v%0d_done_latency", i), done_at, tbl[i].exp_lat);
            chk($sformatf("v%0d_stim_seq", i), int'(stim_ok), 1);
            chk($sformatf("v%0d_err_count", i), int'(ob_err), tbl[i].exp_err);
            chk($sformatf("v%0d_first_vec", i), int'(ob_fv), tbl[i].exp_fv);
            chk($sformatf("v%0d_first_valid", i), int'(ob_fvl), tbl[i].exp_fvl);
            chk($sformatf("v%0d_pass", i), int'(ob_pass), tbl[i].exp_pass);
            chk($sformatf("v%0d_busy_after", i), int'(ob_busy), 0);
            chk($sformatf("v%0d_done_pulse", i), int'(ob_done), 0);
        end

        // Reset while stim==2 aborts the sweep without a done pulse.
        sel = 0; #1;
        kind0 = c_K_OR; mode0 = 2'b00; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        k = 0;
        while (ob_stim != 3'd2 && k < 20) begin @(negedge clk); k++; end
        chk("abort_reach_stim2", int'(ob_stim), 2);
        chk("abort_err_before", int'(ob_err), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy",  int'(ob_busy), 0);
        chk("abort_stim",  int'(ob_stim), 0);
        chk("abort_err",   int'(ob_err),  0);
        chk("abort_fvl",   int'(ob_fvl),  0);
        chk("abort_done",  int'(ob_done), 0);
        rst = 1'b0;
        nd = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (ob_done) nd++;
        end
        chk("abort_no_done", nd, 0);

        // Start held high: back-to-back sweeps, second refreshes results.
        kind0 = c_K_OR; mode0 = 2'b00; start0 = 1'b1;
        @(posedge clk);
        d1 = -1; d2 = -1; nd = 0;
        for (int j = 1; j <= 22; j++) begin
            @(negedge clk);
            if (ob_done) begin
                nd++;
                if (d1 < 0) d1 = j; else d2 = j;
            end
            if (j == 10) begin
                chk("held_idle_busy", int'(ob_busy), 0);
                chk("held_idle_err",  int'(ob_err),  2);
                chk("held_idle_pass", int'(ob_pass), 0);
                kind0 = c_K_AND;
            end
            if (j == 12) start0 = 1'b0;
        end
        chk("held_first_done",  d1, 9);
        chk("held_second_done", d2, 19);
        chk("held_done_count",  nd, 2);
        chk("held_err2",        int'(ob_err),  0);
        chk("held_pass2",       int'(ob_pass), 1);
        chk("held_fvl2",        int'(ob_fvl),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Synthesizable exhaustive stimulus generator and self-checker for an N-input single-output combinational gate DUT.
- On `start`, drives every input vector 0..2^N-1 in ascending order on `stim`, waits a programmable settle time, samples `dut_y` and compares it against the expected value for the selected gate function.
- Reports pass/fail, error count and first failing vector.
- Sits beside a gate DUT in lab benches and on-board self-test, replacing hand-written sweep loops.

Parameters:
- N, 2, DUT input width (1..16).
- SETTLE, 1, cycles `stim` is held before `dut_y` is sampled (>=1).
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin sweep; sampled only in IDLE.
- mode  in  2  gate function: 00 AND, 01 OR, 10 XOR, 11 NAND; latched when `start` is accepted.
- stim  out  N  vector driven to DUT inputs (registered).
- dut_y  in  1  DUT output.
- busy  out  1  high from `start` acceptance until the DONE state is exited.
- done  out  1  one-cycle pulse at sweep completion.
- pass  out  1  1 if the last sweep had zero mismatches; held until next `start` acceptance.
- err_count  out  ERR_W  mismatch count of the current/last sweep; saturating.
- first_err_vec  out  N  `stim` value of the first mismatch.
- first_err_valid  out  1  `first_err_vec` holds a captured value.

Behaviour:
- Reset (rst=1 at edge, any state):
  - state=IDLE
  - stim=0, busy=0, done=0, pass=0
  - err_count=0, first_err_vec=0, first_err_valid=0
  - settle counter=0
  - Reset mid-sweep aborts immediately; no `done` pulse is produced.
- Expected value (from latched mode `m`):
  - AND = &stim
  - OR = |stim
  - XOR = ^stim
  - NAND = ~&stim
- FSM states: IDLE, WAIT, CHECK, DONE.
  - IDLE:
    - On start=1: latch mode; stim<=0; settle<=0; err_count<=0; first_err_valid<=0; first_err_vec<=0; pass<=0; busy<=1; go to WAIT.
    - Otherwise hold all outputs.
  - WAIT:
    - settle<=settle+1.
    - When settle==SETTLE-1, go to CHECK.
  - CHECK (one cycle):
    - Compare `dut_y` with the expected value for the current `stim`.
    - On mismatch: err_count<=err_count+1, saturating at 2^ERR_W-1.
    - On mismatch with first_err_valid=0: first_err_vec<=stim; first_err_valid<=1.
    - If stim==2^N-1: go to DONE.
    - Else: stim<=stim+1; settle<=0; go to WAIT.
  - DONE (one cycle):
    - done=1.
    - pass<=1 if the final err_count (including a mismatch on the last vector) is 0.
    - busy<=0 on exit; go to IDLE.
    - `stim` holds 2^N-1.
- Timing:
  - Each vector occupies SETTLE+1 cycles (SETTLE in WAIT, 1 in CHECK).
  - `done` is asserted exactly 2^N*(SETTLE+1)+1 cycles after the edge that accepted `start`.
- `start` while busy=1 is ignored; mode changes while busy are ignored.
- `start` held high continuously: a new sweep begins on the first cycle back in IDLE (the cycle after DONE).
- `stim` wrap-around never occurs; the counter stops at 2^N-1.
- Saturation: err_count stops at all-ones and further mismatches do not wrap; pass=0 in that case.
- X/Z on `dut_y` during CHECK counts as a mismatch; the verification model uses a case-inequality compare.

Test Plan:
- N=2, SETTLE=1, mode=AND, correct AND DUT, pulse start → stim steps 0,1,2,3 (2 cycles each); done pulses 9 cycles after acceptance; pass=1; err_count=0; first_err_valid=0.
- N=2, SETTLE=1, mode=AND, DUT is an OR gate → mismatches at stim=01 and 10; err_count=2; first_err_vec=01; first_err_valid=1; pass=0.
- N=3, SETTLE=2, mode=XOR, correct XOR DUT → 8 vectors × 3 cycles; done at cycle 25 after acceptance; pass=1.
- N=3, ERR_W=2, mode=NAND, dut_y stuck at 0 → 7 mismatches; err_count saturates at 3; first_err_vec=000; pass=0.
- During a sweep, pulse start and toggle mode → no restart; sweep completes with the original mode's results. Then assert rst at stim=2 → next cycle: IDLE, busy=0, stim=0, err_count=0, and no done pulse.
- start held high across two sweeps → done pulses twice; the second sweep begins the cycle after the first DONE; pass/err_count refresh for the second sweep.
